kamus_fetch_buffer: RTL

Instruction fetch buffer between the instruction memory port and the kamus_core fetch stage. It issues sequential word fetches on a request/grant/response memory interface and holds returned instructions with their addresses in a small in-order FIFO. It presents them to the core on a valid/ready handshake. On a redirect from the core (branch, jump, trap), it flushes its buffer and discards in-flight responses.

---
 rtl/kamus_pkg.sv | 13 +
 rtl/kamus_sync_fifo.sv | 60 ++++++
 rtl/kamus_fetch_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus instruction fetch path.
package kamus_pkg;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/kamus_sync_fifo.sv
// Small in-order FIFO with a combinational head, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module kamus_sync_fifo #(
    parameter type elem_t = logic [63:0],
    parameter int  DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  elem_t                        push_data,
    input  logic                         pop,
    input  logic                         flush,
    output elem_t                        head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    elem_t          mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    // Storage write; a flush wins over a push so nothing stale survives it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/kamus_fetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches, buffers the
// responses in order and hands them to the core on a valid/ready handshake.
// A redirect flushes the buffer and drops every response still in flight.
// Optional build macro KAMUS_FETCH_BYPASS_EN: a response arriving while the
// buffer is empty is presented to the core in the same cycle.
module kamus_fetch_buffer
    import kamus_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i
);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0]    START_PC = RESET_PC & INSTR_ALIGN_MASK;

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   resp_pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_count_reg;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          grant;
    logic          resp_keep;
    logic          resp_drop;
    logic          bypass;

    // Buffered plus in-flight instructions never exceed DEPTH, which is what
    // makes a FIFO overflow impossible.
    assign occupancy   = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign imem_req_o  = !rst_i && !redirect_i && (occupancy < DEPTH_W);
    assign imem_addr_o = rst_i ? START_PC : fetch_pc_reg;
    assign grant       = imem_req_o && imem_gnt_i;
    assign redirect_pc = redirect_addr_i & INSTR_ALIGN_MASK;

    // A response is kept only if it is not owed to an older, flushed stream and
    // does not coincide with a redirect.
    assign resp_keep   = imem_rvalid_i && (drop_count_reg == '0) && !redirect_i;
    assign resp_drop   = imem_rvalid_i && (drop_count_reg != '0);
    assign outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid_i);

`ifdef KAMUS_FETCH_BYPASS_EN
    assign bypass = fifo_empty && resp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry = '{addr: resp_pc_reg, data: imem_rdata_i};
    // A bypassed response taken by the core the same cycle is never stored.
    assign fifo_push  = resp_keep && !(bypass && instr_ready_i);
    assign fifo_pop   = instr_valid_o && instr_ready_i && !fifo_empty;

    kamus_sync_fifo #(
        .elem_t (fetch_entry_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_i),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Core-facing outputs: FIFO head, or the live response when bypassing; zero otherwise.
    always_comb begin
        instr_valid_o = 1'b0;
        instr_data_o  = '0;
        instr_addr_o  = '0;
        if (!rst_i) begin
            if (!fifo_empty) begin
                instr_valid_o = 1'b1;
                instr_data_o  = head_entry.data;
                instr_addr_o  = head_entry.addr;
            end else if (bypass) begin
                instr_valid_o = 1'b1;
                instr_data_o  = imem_rdata_i;
                instr_addr_o  = resp_pc_reg;
            end
        end
    end

    // Fetch/response address tracking and in-flight accounting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_reg    <= START_PC;
            resp_pc_reg     <= START_PC;
            outstanding_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (redirect_i) begin
                fetch_pc_reg   <= redirect_pc;
                resp_pc_reg    <= redirect_pc;
                drop_count_reg <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (resp_keep) begin
                    resp_pc_reg <= resp_pc_reg + 32'd4;
                end
                if (resp_drop) begin
                    drop_count_reg <= drop_count_reg - CW'(1);
                end
            end
        end
    end

    // The capacity rule must keep pushes away from a full FIFO.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
